// File: rtl/store_buffer_pkg.sv
// Store buffer types: entry layout, drain states and the byte-lane merge helper.
`include "defines.v"
package store_buffer_pkg;
   localparam int ADDR_W       = `Addr_Width;
   localparam int DATA_W       = `Data_Width;
   localparam int LANES        = DATA_W / 8;
   localparam int SB_DEPTH_DEF = `SB_DEPTH;

   typedef enum logic {
      S_IDLE = `SB_ST_IDLE,
      S_REQ  = `SB_ST_REQ
   } sb_state_t;

   typedef struct packed {
      logic [ADDR_W-3:0] waddr;
      logic [LANES-1:0]  mask;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   // New bytes replace old ones lane by lane; the masks accumulate.
   function automatic sb_entry_t merge_entry(input sb_entry_t old_e, input sb_entry_t new_e);
      merge_entry      = old_e;
      merge_entry.mask = old_e.mask | new_e.mask;
      for (int b = 0; b < LANES; b++) begin
         if (new_e.mask[b]) merge_entry.data[8*b +: 8] = new_e.data[8*b +: 8];
      end
   endfunction
endpackage

// File: rtl/defines.v
// Shared widths, drain FSM encodings and default buffer depth.
`ifndef STORE_BUFFER_DEFINES_V
`define STORE_BUFFER_DEFINES_V
`define Addr_Width 32
`define Data_Width 32
`define SB_DEPTH   4
`define SB_ST_IDLE 1'b0
`define SB_ST_REQ  1'b1
`endif

// File: rtl/store_fwd_merge.sv
// Combinational load forwarding: oldest-to-youngest scan, younger matching lanes win.
module store_fwd_merge
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEF
) (
   input  sb_entry_t [DEPTH-1:0] i_ent,
   input  logic      [DEPTH-1:0] i_vld,
   input  logic [ADDR_W-3:0]     i_waddr,
   output logic [LANES-1:0]      o_mask,
   output logic [DATA_W-1:0]     o_data
);
   always_comb begin
      o_mask = '0;
      o_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_vld[i] && (i_ent[i].waddr == i_waddr)) begin
            for (int b = 0; b < LANES; b++) begin
               if (i_ent[i].mask[b]) begin
                  o_mask[b]          = 1'b1;
                  o_data[8*b +: 8]   = i_ent[i].data[8*b +: 8];
               end
            end
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO draining to memory one write at a time (mem_write from the edge after accept);
// accepts only while not full. STORE_BUFFER_MERGE_EN merges same-word stores into the youngest entry.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dcache_write,
   input  logic [LANES-1:0]  dcache_mask,
   input  logic [ADDR_W-1:0] dcache_addr,
   input  logic [DATA_W-1:0] dcache_data,
   output logic              dcache_write_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic [LANES-1:0]  ld_fwd_mask,
   output logic [DATA_W-1:0] ld_fwd_data,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LANES-1:0]  mem_mask,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   output logic              sb_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t             r_ent [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;
   sb_state_t             r_state;
   sb_state_t             w_state_nxt;
   logic [CNT_W-1:0]      w_count_nxt;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   sb_entry_t             w_new;
   sb_entry_t             w_head;
   sb_entry_t [DEPTH-1:0] w_ord;
   logic [DEPTH-1:0]      w_ord_vld;
   logic                  w_unused;

   assign w_unused = ^{dcache_addr[1:0], ld_addr[1:0]};
   assign w_new    = '{waddr: dcache_addr[ADDR_W-1:2], mask: dcache_mask, data: dcache_data};
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_head   = r_ent[r_rd_ptr];
   assign w_pop    = (r_state == S_REQ) && mem_ack;

`ifdef STORE_BUFFER_MERGE_EN
   logic [PTR_W-1:0] w_yng_ptr;
   logic             w_merge_ok;
   logic             w_merge;

   // The head under an outstanding request must not change, so it is never a merge target.
   assign w_yng_ptr  = r_wr_ptr - PTR_W'(1);
   assign w_merge_ok = (r_count != '0) && (r_ent[w_yng_ptr].waddr == w_new.waddr) &&
                       !((r_state == S_REQ) && (r_count == CNT_W'(1)));
   assign dcache_write_valid = !w_full || w_merge_ok;
   assign w_merge = dcache_write && w_merge_ok;
   assign w_push  = dcache_write && !w_merge_ok && !w_full;

   always_ff @(posedge clk) begin
      if (w_push)       r_ent[r_wr_ptr]  <= w_new;
      else if (w_merge) r_ent[w_yng_ptr] <= merge_entry(r_ent[w_yng_ptr], w_new);
   end
`else
   assign dcache_write_valid = !w_full;
   assign w_push = dcache_write && !w_full;

   always_ff @(posedge clk) begin
      if (w_push) r_ent[r_wr_ptr] <= w_new;
   end
`endif

   assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_write   = 1'b0;
      case (r_state)
         S_IDLE: if (r_count != '0) w_state_nxt = S_REQ;
         S_REQ: begin
            mem_write = 1'b1;
            if (w_pop && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign mem_addr = mem_write ? {w_head.waddr, 2'b00} : '0;
   assign mem_mask = mem_write ? w_head.mask : '0;
   assign mem_data = mem_write ? w_head.data : '0;
   assign sb_empty = (r_count == '0) && (r_state == S_IDLE);

   // Present entries oldest first so the forwarding scan needs no pointer arithmetic.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ord[i]     = r_ent[r_rd_ptr + PTR_W'(i)];
         w_ord_vld[i] = (CNT_W'(i) < r_count);
      end
   end

   store_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
      .i_ent   (w_ord),
      .i_vld   (w_ord_vld),
      .i_waddr (ld_addr[ADDR_W-1:2]),
      .o_mask  (ld_fwd_mask),
      .o_data  (ld_fwd_data)
   );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: accept/drain order, full handling, forwarding, reset.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic              clk;
   logic              rst;
   logic              dcache_write;
   logic [3:0]        dcache_mask;
   logic [ADDR_W-1:0] dcache_addr;
   logic [DATA_W-1:0] dcache_data;
   logic              dcache_write_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [3:0]        ld_fwd_mask;
   logic [DATA_W-1:0] ld_fwd_data;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_mask;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ack;
   logic              sb_empty;

   int n_chk = 0;
   int n_err = 0;

   store_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .dcache_write       (dcache_write),
      .dcache_mask        (dcache_mask),
      .dcache_addr        (dcache_addr),
      .dcache_data        (dcache_data),
      .dcache_write_valid (dcache_write_valid),
      .ld_addr            (ld_addr),
      .ld_fwd_mask        (ld_fwd_mask),
      .ld_fwd_data        (ld_fwd_data),
      .mem_write          (mem_write),
      .mem_addr           (mem_addr),
      .mem_mask           (mem_mask),
      .mem_data           (mem_data),
      .mem_ack            (mem_ack),
      .sb_empty           (sb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      dcache_write = 1'b1;
      dcache_addr  = a;
      dcache_mask  = m;
      dcache_data  = d;
      tick();
      dcache_write = 1'b0;
   endtask

   task automatic ack_pulse();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      dcache_write = 1'b0;
      dcache_mask  = '0;
      dcache_addr  = '0;
      dcache_data  = '0;
      ld_addr      = '0;
      mem_ack      = 1'b0;
      #2;
      chk("rst_wr_valid", 32'(dcache_write_valid), 32'd1);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_empty", 32'(sb_empty), 32'd1);
      chk("rst_fwd_mask", 32'(ld_fwd_mask), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Single store: latency, head contents, forwarding, stability without ack
      push(32'h100, 4'b0011, 32'h0000BEEF);
      chk("lat_edgeN", 32'(mem_write), 32'd0);
      chk("lat_not_empty", 32'(sb_empty), 32'd0);
      tick();
      chk("lat_edgeN1", 32'(mem_write), 32'd1);
      chk("s1_addr", mem_addr, 32'h100);
      chk("s1_mask", 32'(mem_mask), 32'h3);
      chk("s1_data", mem_data, 32'h0000BEEF);
      ld_addr = 32'h102;
      #1;
      chk("s1_fwd_mask", 32'(ld_fwd_mask), 32'h3);
      chk("s1_fwd_data", ld_fwd_data, 32'h0000BEEF);
      tick();
      chk("s1_hold_addr", mem_addr, 32'h100);
      chk("s1_hold_wr", 32'(mem_write), 32'd1);
      ack_pulse();
      chk("s1_empty", 32'(sb_empty), 32'd1);
      chk("s1_idle", 32'(mem_write), 32'd0);

      // Fill to full, drop a fifth store, drain in order
      for (int k = 0; k < 4; k++) push(32'h10 + 32'(4*k), 4'hF, 32'hA0 + 32'(k));
      chk("full_valid", 32'(dcache_write_valid), 32'd0);
      push(32'h40, 4'hF, 32'hDEAD);
      chk("full_valid2", 32'(dcache_write_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("drain_addr", mem_addr, 32'h10 + 32'(4*k));
         chk("drain_data", mem_data, 32'hA0 + 32'(k));
         ack_pulse();
         if (k == 0) chk("drain_freed", 32'(dcache_write_valid), 32'd1);
      end
      chk("drain_empty", 32'(sb_empty), 32'd1);
      chk("drain_idle", 32'(mem_write), 32'd0);

      // Same word twice with the first already the requesting head
      push(32'h20, 4'b0001, 32'h000000AA);
      tick();
      push(32'h20, 4'b1001, 32'hBB0000CC);
      ld_addr = 32'h20;
      #1;
      chk("ovr_fwd_mask", 32'(ld_fwd_mask), 32'h9);
      chk("ovr_fwd_data", ld_fwd_data, 32'hBB0000CC);
      ld_addr = 32'h24;
      #1;
      chk("miss_fwd_mask", 32'(ld_fwd_mask), 32'h0);
      chk("miss_fwd_data", ld_fwd_data, 32'h0);
      chk("ovr_head_mask", 32'(mem_mask), 32'h1);
      chk("ovr_head_data", mem_data, 32'h000000AA);
      ack_pulse();
      chk("ovr_second_wr", 32'(mem_write), 32'd1);
      chk("ovr_second_mask", 32'(mem_mask), 32'h9);
      chk("ovr_second_data", mem_data, 32'hBB0000CC);
      ack_pulse();
      chk("ovr_empty", 32'(sb_empty), 32'd1);

      // Empty-mask store still occupies an entry and drains unchanged
      push(32'h90, 4'b0000, 32'h12345678);
      ld_addr = 32'h90;
      #1;
      chk("m0_fwd_mask", 32'(ld_fwd_mask), 32'h0);
      chk("m0_fwd_data", ld_fwd_data, 32'h0);
      tick();
      chk("m0_wr", 32'(mem_write), 32'd1);
      chk("m0_mask", 32'(mem_mask), 32'h0);
      chk("m0_data", mem_data, 32'h12345678);
      ack_pulse();
      chk("m0_empty", 32'(sb_empty), 32'd1);

      // Full buffer: store and ack in the same cycle
      for (int k = 0; k < 4; k++) push(32'h50 + 32'(4*k), 4'hF, 32'h50 + 32'(k));
      dcache_write = 1'b1;
      dcache_addr  = 32'h60;
      dcache_mask  = 4'hF;
      dcache_data  = 32'h66;
      mem_ack      = 1'b1;
      #1;
      chk("fa_valid_before", 32'(dcache_write_valid), 32'd0);
      tick();
      dcache_write = 1'b0;
      mem_ack      = 1'b0;
      chk("fa_valid_after", 32'(dcache_write_valid), 32'd1);
      chk("fa_head", mem_addr, 32'h54);
      for (int k = 0; k < 3; k++) ack_pulse();
      chk("fa_empty", 32'(sb_empty), 32'd1);

      // Reset mid-request with three entries
      push(32'h70, 4'hF, 32'h70);
      push(32'h74, 4'hF, 32'h74);
      push(32'h78, 4'hF, 32'h78);
      chk("mr_req", 32'(mem_write), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_wr_drop", 32'(mem_write), 32'd0);
      chk("mr_empty", 32'(sb_empty), 32'd1);
      chk("mr_addr", mem_addr, 32'h0);
      chk("mr_valid", 32'(dcache_write_valid), 32'd1);
      tick();
      rst = 1'b0;
      push(32'h80, 4'hF, 32'h88);
      tick();
      chk("mr_first_wr", 32'(mem_write), 32'd1);
      chk("mr_first_addr", mem_addr, 32'h80);
      chk("mr_first_data", mem_data, 32'h88);
      ack_pulse();
      chk("mr_final_empty", 32'(sb_empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
